// File: rtl/instruction_fetch_unit_pkg.sv
// Shared processor definitions: fetch state encoding and opcode constants
// used by fetch, dispatch and the reservation stations.
package instruction_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  localparam logic [3:0] OP_HALT = 4'hF;

  function automatic logic is_halt_op(input logic [3:0] opcode);
    return (opcode == OP_HALT);
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_skid.sv
// Two-entry skid FIFO (module fetch_skid_buffer) holding fetched {instr, pc}
// pairs between the instruction memory and the dispatch queue.
module fetch_skid_buffer #(
  parameter int WIDTH = 21
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic [1:0]       o_count
);

  logic [WIDTH-1:0] r_entry [2];
  logic             r_rd_ptr;
  logic             r_wr_ptr;
  logic [1:0]       r_count;

  // Entry storage, pointers and occupancy; flush discards contents without touching data.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_entry[0] <= {WIDTH{1'b0}};
      r_entry[1] <= {WIDTH{1'b0}};
      r_rd_ptr   <= 1'b0;
      r_wr_ptr   <= 1'b0;
      r_count    <= 2'd0;
    end else if (i_flush) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_wr_en) begin
        r_entry[r_wr_ptr] <= i_wr_data;
        r_wr_ptr          <= ~r_wr_ptr;
      end
      if (i_rd_en) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({i_wr_en, i_rd_en})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rd_data = r_entry[r_rd_ptr];
  assign o_count   = r_count;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: streams words from a 1-cycle-latency memory into the dispatch
// queue through a 2-entry skid buffer. Optional halt-on-opcode via FETCH_HALT_EN.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int ADDR_WIDTH  = 5,
  parameter int INSTR_WIDTH = 16
) (
  input  logic                   Clock,
  input  logic                   Reset,
  output logic [ADDR_WIDTH-1:0]  ImemAddr,
  output logic                   ImemRe,
  input  logic [INSTR_WIDTH-1:0] ImemData,
  output logic                   Push,
  output logic [INSTR_WIDTH-1:0] PushInstr,
  output logic [ADDR_WIDTH-1:0]  PushPC,
  input  logic                   Full,
  input  logic                   Redirect,
  input  logic [ADDR_WIDTH-1:0]  RedirectPC,
  output logic                   Halted
);

  localparam int ENTRY_WIDTH = INSTR_WIDTH + ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PC_STEP = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  fetch_state_e            r_state;
  fetch_state_e            w_next_state;
  logic [ADDR_WIDTH-1:0]   r_pc;
  logic [ADDR_WIDTH-1:0]   w_next_pc;
  logic [ADDR_WIDTH-1:0]   r_inflight_pc;
  logic                    r_inflight;
  logic                    w_issue;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_wr;
  logic                    w_halt_hit;
  logic [1:0]              w_count;
  logic [2:0]              w_occupancy;
  logic [ENTRY_WIDTH-1:0]  w_head;

  assign w_push = (w_count != 2'd0) && !Redirect;
  assign w_pop  = w_push && !Full;
  // Returns are only accepted in RUN, so a halt drops anything still in flight.
  assign w_wr   = r_inflight && (r_state == ST_RUN) && !Redirect;
  // Entries the buffer will hold next cycle; a new read is safe only if room remains.
  assign w_occupancy = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};

`ifdef FETCH_HALT_EN
  assign w_halt_hit = w_wr && is_halt_op(ImemData[INSTR_WIDTH-1 -: 4]);
  assign Halted     = (r_state == ST_HALT);
`else
  assign w_halt_hit = 1'b0;
  assign Halted     = 1'b0;
`endif

  // Next state, next PC and read issue; redirect overrides everything else.
  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_issue      = 1'b0;
    if (Redirect) begin
      w_next_state = ST_RUN;
      w_next_pc    = RedirectPC;
    end else begin
      case (r_state)
        ST_IDLE: w_next_state = ST_RUN;
        ST_RUN: begin
          if (w_halt_hit) begin
            w_next_state = ST_HALT;
          end else if (w_occupancy < 3'd2) begin
            w_issue   = 1'b1;
            w_next_pc = r_pc + PC_STEP;
          end else begin
            w_next_state = ST_RUN;
          end
        end
        ST_HALT: w_next_state = ST_HALT;
        default: w_next_state = ST_IDLE;
      endcase
    end
  end

  // State, PC and in-flight tracking.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_state       <= ST_IDLE;
      r_pc          <= {ADDR_WIDTH{1'b0}};
      r_inflight    <= 1'b0;
      r_inflight_pc <= {ADDR_WIDTH{1'b0}};
    end else begin
      r_state    <= w_next_state;
      r_pc       <= w_next_pc;
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= r_pc;
      end else begin
        r_inflight_pc <= r_inflight_pc;
      end
    end
  end

  fetch_skid_buffer #(
    .WIDTH(ENTRY_WIDTH)
  ) u_skid (
    .i_clk     (Clock),
    .i_rst_n   (Reset),
    .i_flush   (Redirect),
    .i_wr_en   (w_wr),
    .i_wr_data ({ImemData, r_inflight_pc}),
    .i_rd_en   (w_pop),
    .o_rd_data (w_head),
    .o_count   (w_count)
  );

  assign ImemRe    = w_issue;
  assign ImemAddr  = r_pc;
  assign Push      = w_push;
  assign PushInstr = w_head[ENTRY_WIDTH-1 -: INSTR_WIDTH];
  assign PushPC    = w_head[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit; memory word i holds 16'h1000+i.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  imem_addr;
  logic        imem_re;
  logic [15:0] imem_data = 16'h0000;
  logic        push;
  logic [15:0] push_instr;
  logic [4:0]  push_pc;
  logic        full;
  logic        redirect;
  logic [4:0]  redirect_pc;
  logic        halted;

  logic [15:0] mem [0:31];
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_re) imem_data <= mem[imem_addr];
  end

  instruction_fetch_unit #(.ADDR_WIDTH(5), .INSTR_WIDTH(16)) dut (
    .Clock(clk), .Reset(reset_n), .ImemAddr(imem_addr), .ImemRe(imem_re),
    .ImemData(imem_data), .Push(push), .PushInstr(push_instr), .PushPC(push_pc),
    .Full(full), .Redirect(redirect), .RedirectPC(redirect_pc), .Halted(halted)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive inputs on the falling edge, then settle before sampling.
  task automatic cyc(input logic f, input logic rd, input logic [4:0] rpc, input logic rst);
    @(negedge clk);
    full = f; redirect = rd; redirect_pc = rpc; reset_n = rst;
    #1;
  endtask

  task automatic chk_push(input string tag, input logic [4:0] pc);
    check_val({tag, "_push"}, 32'(push), 32'd1);
    check_val({tag, "_pc"}, 32'(push_pc), 32'(pc));
    check_val({tag, "_instr"}, 32'(push_instr), 32'(16'h1000 + 16'(pc)));
  endtask

  logic [31:0] full_pat;
  logic [4:0]  exp_pc;
  int          n_acc;

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 16'h1000 + 16'(i);
    reset_n = 1'b0; full = 1'b0; redirect = 1'b0; redirect_pc = 5'd0;
    repeat (3) @(posedge clk);

    // basic stream after reset
    cyc(1'b0, 1'b0, 5'd0, 1'b1);
    check_val("rst_imemre", 32'(imem_re), 32'd0);
    check_val("rst_push", 32'(push), 32'd0);
    check_val("rst_addr", 32'(imem_addr), 32'd0);
    check_val("rst_pushpc", 32'(push_pc), 32'd0);
    check_val("rst_instr", 32'(push_instr), 32'd0);
    check_val("rst_halted", 32'(halted), 32'd0);
    cyc(1'b0, 1'b0, 5'd0, 1'b1);
    check_val("s1_re0", 32'(imem_re), 32'd1);
    check_val("s1_addr0", 32'(imem_addr), 32'd0);
    check_val("s1_nopush0", 32'(push), 32'd0);
    cyc(1'b0, 1'b0, 5'd0, 1'b1);
    check_val("s1_addr1", 32'(imem_addr), 32'd1);
    check_val("s1_nopush1", 32'(push), 32'd0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 5'd0, 1'b1);
      chk_push("s1", 5'(i));
    end

    // Full held while PushPC=1 is presented
    cyc(1'b0, 1'b0, 5'd0, 1'b0);
    cyc(1'b0, 1'b0, 5'd0, 1'b0);
    cyc(1'b0, 1'b0, 5'd0, 1'b1);
    cyc(1'b0, 1'b0, 5'd0, 1'b1);
    cyc(1'b0, 1'b0, 5'd0, 1'b1);
    cyc(1'b0, 1'b0, 5'd0, 1'b1);
    chk_push("s2_c", 5'd0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0, 5'd0, 1'b1);
      chk_push("s2_full", 5'd1);
      check_val("s2_re_stop", 32'(imem_re), 32'd0);
    end
    cyc(1'b0, 1'b0, 5'd0, 1'b1);
    chk_push("s2_r1", 5'd1);
    check_val("s2_re_resume", 32'(imem_re), 32'd1);
    check_val("s2_addr3", 32'(imem_addr), 32'd3);
    cyc(1'b0, 1'b0, 5'd0, 1'b1);
    chk_push("s2_r2", 5'd2);
    cyc(1'b0, 1'b0, 5'd0, 1'b1);
    chk_push("s2_r3", 5'd3);

    // redirect to 20 with in-flight read and stalled queue
    cyc(1'b1, 1'b1, 5'd20, 1'b1);
    check_val("s3_nopush", 32'(push), 32'd0);
    check_val("s3_nore", 32'(imem_re), 32'd0);
    cyc(1'b0, 1'b0, 5'd0, 1'b1);
    check_val("s3_re20", 32'(imem_re), 32'd1);
    check_val("s3_addr20", 32'(imem_addr), 32'd20);
    check_val("s3_nopush1", 32'(push), 32'd0);
    cyc(1'b0, 1'b0, 5'd0, 1'b1);
    check_val("s3_nopush2", 32'(push), 32'd0);
    for (int i = 20; i < 23; i++) begin
      cyc(1'b0, 1'b0, 5'd0, 1'b1);
      chk_push("s3", 5'(i));
    end

    // PC wrap from 31 to 0
    cyc(1'b0, 1'b1, 5'd30, 1'b1);
    check_val("s4_nopush", 32'(push), 32'd0);
    cyc(1'b0, 1'b0, 5'd0, 1'b1);
    check_val("s4_addr30", 32'(imem_addr), 32'd30);
    cyc(1'b0, 1'b0, 5'd0, 1'b1);
    check_val("s4_addr31", 32'(imem_addr), 32'd31);
    cyc(1'b0, 1'b0, 5'd0, 1'b1);
    chk_push("s4_30", 5'd30);
    check_val("s4_addr_wrap", 32'(imem_addr), 32'd0);
    cyc(1'b0, 1'b0, 5'd0, 1'b1);
    chk_push("s4_31", 5'd31);
    cyc(1'b0, 1'b0, 5'd0, 1'b1);
    chk_push("s4_0", 5'd0);
    cyc(1'b0, 1'b0, 5'd0, 1'b1);
    chk_push("s4_1", 5'd1);

    // opcode F at word 3
    mem[3] = 16'hF000;
    cyc(1'b0, 1'b1, 5'd0, 1'b1);
    cyc(1'b0, 1'b0, 5'd0, 1'b1);
    cyc(1'b0, 1'b0, 5'd0, 1'b1);
    cyc(1'b0, 1'b0, 5'd0, 1'b1);
    chk_push("s5_0", 5'd0);
    cyc(1'b0, 1'b0, 5'd0, 1'b1);
    chk_push("s5_1", 5'd1);
    cyc(1'b0, 1'b0, 5'd0, 1'b1);
    chk_push("s5_2", 5'd2);
`ifdef FETCH_HALT_EN
    check_val("s5_re_halt", 32'(imem_re), 32'd0);
`else
    check_val("s5_re4", 32'(imem_re), 32'd1);
    check_val("s5_addr4", 32'(imem_addr), 32'd4);
`endif
    cyc(1'b0, 1'b0, 5'd0, 1'b1);
    check_val("s5_3_push", 32'(push), 32'd1);
    check_val("s5_3_pc", 32'(push_pc), 32'd3);
    check_val("s5_3_instr", 32'(push_instr), 32'hF000);
    cyc(1'b0, 1'b0, 5'd0, 1'b1);
`ifdef FETCH_HALT_EN
    check_val("s5_halted", 32'(halted), 32'd1);
    check_val("s5_halt_nopush", 32'(push), 32'd0);
    check_val("s5_halt_nore", 32'(imem_re), 32'd0);
`else
    check_val("s5_not_halted", 32'(halted), 32'd0);
    chk_push("s5_4", 5'd4);
`endif
    cyc(1'b0, 1'b1, 5'd8, 1'b1);
    check_val("s5_redir_nopush", 32'(push), 32'd0);
    cyc(1'b0, 1'b0, 5'd0, 1'b1);
    check_val("s5_halt_clr", 32'(halted), 32'd0);
    check_val("s5_addr8", 32'(imem_addr), 32'd8);
    check_val("s5_re8", 32'(imem_re), 32'd1);
    cyc(1'b0, 1'b0, 5'd0, 1'b1);
    cyc(1'b0, 1'b0, 5'd0, 1'b1);
    chk_push("s5_8", 5'd8);
    cyc(1'b0, 1'b0, 5'd0, 1'b1);
    chk_push("s5_9", 5'd9);
    mem[3] = 16'h1003;

    // reset asserted mid-stream while Full
    cyc(1'b0, 1'b1, 5'd0, 1'b1);
    cyc(1'b0, 1'b0, 5'd0, 1'b1);
    cyc(1'b0, 1'b0, 5'd0, 1'b1);
    cyc(1'b0, 1'b0, 5'd0, 1'b1);
    chk_push("s6_0", 5'd0);
    cyc(1'b1, 1'b0, 5'd0, 1'b0);
    chk_push("s6_pre", 5'd1);
    cyc(1'b0, 1'b0, 5'd0, 1'b1);
    check_val("s6_nopush", 32'(push), 32'd0);
    check_val("s6_nore", 32'(imem_re), 32'd0);
    check_val("s6_pc0", 32'(imem_addr), 32'd0);
    check_val("s6_pushpc0", 32'(push_pc), 32'd0);
    cyc(1'b0, 1'b0, 5'd0, 1'b1);
    check_val("s6_re0", 32'(imem_re), 32'd1);
    check_val("s6_addr0", 32'(imem_addr), 32'd0);
    cyc(1'b0, 1'b0, 5'd0, 1'b1);
    cyc(1'b0, 1'b0, 5'd0, 1'b1);
    chk_push("s6_first", 5'd0);
    cyc(1'b0, 1'b0, 5'd0, 1'b1);
    chk_push("s6_second", 5'd1);

    // Full toggling: every accepted push must be the next PC, no gaps or repeats
    full_pat = 32'hB2E5_4A71;
    exp_pc = 5'd2;
    n_acc = 0;
    for (int i = 0; i < 32; i++) begin
      cyc(full_pat[i], 1'b0, 5'd0, 1'b1);
      check_val("s7_push", 32'(push), 32'd1);
      if (push && !full) begin
        check_val("s7_pc", 32'(push_pc), 32'(exp_pc));
        check_val("s7_instr", 32'(push_instr), 32'(16'h1000 + 16'(exp_pc)));
        exp_pc = exp_pc + 5'd1;
        n_acc++;
      end
    end
    check_val("s7_accepted", 32'(n_acc), 32'd16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
